// File: rtl/cp0_ctrl_pkg.sv
// CP0 shared definitions: register addresses, exception codes and
// helpers that pack the Status and Cause register images.
package cp0_ctrl_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    function automatic logic [31:0] pack_status(input logic [7:0] im,
                                                input logic exl,
                                                input logic ie);
        return {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd,
                                               input logic ti,
                                               input logic [7:0] ip,
                                               input logic [4:0] exc_code);
        return {bd, ti, 14'd0, ip, 1'b0, exc_code, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled free-running Count and the timer
// interrupt flag TI raised when an increment lands on Compare.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_wen,
    input  logic        compare_wen,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam logic [3:0] PRESC_LAST = 4'(COUNT_DIV - 1);

    logic [3:0]  presc_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        ti_r;
    logic        tick_s;
    logic [31:0] count_inc_s;

    assign tick_s      = (presc_r == PRESC_LAST);
    assign count_inc_s = count_r + 32'd1;

    // Prescaler and Count; an mtc0 Count reloads both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= 4'd0;
            count_r <= 32'd0;
        end else if (count_wen) begin
            presc_r <= 4'd0;
            count_r <= wdata;
        end else if (tick_s) begin
            presc_r <= 4'd0;
            count_r <= count_inc_s;
        end else begin
            presc_r <= presc_r + 4'd1;
        end
    end

    // Compare register and TI; a Compare write beats a same-cycle match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare_r <= 32'd0;
            ti_r      <= 1'b0;
        end else if (compare_wen) begin
            compare_r <= wdata;
            ti_r      <= 1'b0;
        end else if (tick_s && !count_wen && (count_inc_s == compare_r)) begin
            ti_r <= 1'b1;
        end else begin
            ti_r <= ti_r;
        end
    end

    assign count   = count_r;
    assign compare = compare_r;
    assign ti      = ti_r;

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 control block: Status/Cause/EPC/BadVAddr state, interrupt request
// generation, exception/eret commit and the pipeline redirect pulse.
module cp0_ctrl
    import cp0_ctrl_pkg::*;
#(
    parameter int          N_HW_INT   = 5,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] EPC_RESET  = 32'hBFC00000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          raddr,
    output logic [31:0]         rdata,
    input  logic                wen,
    input  logic [4:0]          waddr,
    input  logic [31:0]         wdata,
    input  logic [N_HW_INT-1:0] hw_int,
    input  logic                exc_valid,
    input  logic [4:0]          exc_code,
    input  logic [31:0]         exc_pc,
    input  logic                exc_bd,
    input  logic                exc_bad_valid,
    input  logic [31:0]         exc_badvaddr,
    input  logic                eret,
    output logic                int_req,
    input  logic                int_ack,
    input  logic [31:0]         int_pc,
    input  logic                int_bd,
    output logic                flush,
    output logic [31:0]         flush_target,
    output logic [31:0]         epc
);

    logic [N_HW_INT-1:0] sync1_r, sync2_r;
    logic [7:0]  im_r;
    logic        exl_r, ie_r, bd_r;
    logic [1:0]  ip_sw_r;
    logic [4:0]  exc_code_r;
    logic [31:0] epc_r, badvaddr_r, flush_target_r;
    logic        int_req_r, flush_r;

    logic [7:0]  im_nxt_s;
    logic        exl_nxt_s, ie_nxt_s, bd_nxt_s, flush_nxt_s;
    logic [1:0]  ip_sw_nxt_s;
    logic [4:0]  exc_code_nxt_s;
    logic [31:0] epc_nxt_s, badvaddr_nxt_s, flush_target_nxt_s;
    logic        int_req_nxt_s;

    logic [31:0] count_s, compare_s;
    logic        ti_s, ack_s;
    logic [4:0]  ip_hw_s;
    logic [7:0]  ip_s;
    logic [31:0] status_rd_s, cause_rd_s, count_rd_s, compare_rd_s, epc_rd_s;

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .count_wen   (wen && (waddr == CP0_COUNT)),
        .compare_wen (wen && (waddr == CP0_COMPARE)),
        .wdata       (wdata),
        .count       (count_s),
        .compare     (compare_s),
        .ti          (ti_s)
    );

    // Zero-extend the synchronised lines into the IP[6:2] slot.
    always_comb begin
        ip_hw_s                 = 5'd0;
        ip_hw_s[N_HW_INT-1:0]   = sync2_r;
    end

    assign ip_s  = {ti_s, ip_hw_s, ip_sw_r};
    // An acknowledge is only honoured while a request is actually raised.
    assign ack_s = int_ack && int_req_r;

    // Two-flop synchroniser for the asynchronous interrupt lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= hw_int;
            sync2_r <= sync1_r;
        end
    end

    // Next state: mtc0 first, then eret/exception/interrupt override it.
    always_comb begin
        im_nxt_s           = im_r;
        exl_nxt_s          = exl_r;
        ie_nxt_s           = ie_r;
        bd_nxt_s           = bd_r;
        ip_sw_nxt_s        = ip_sw_r;
        exc_code_nxt_s     = exc_code_r;
        epc_nxt_s          = epc_r;
        badvaddr_nxt_s     = badvaddr_r;
        flush_nxt_s        = 1'b0;
        flush_target_nxt_s = flush_target_r;
        if (wen) begin
            case (waddr)
                CP0_STATUS: begin
                    im_nxt_s  = wdata[15:8];
                    exl_nxt_s = wdata[1];
                    ie_nxt_s  = wdata[0];
                end
                CP0_CAUSE: ip_sw_nxt_s = wdata[9:8];
                CP0_EPC:   epc_nxt_s   = wdata;
                default:   ip_sw_nxt_s = ip_sw_r;
            endcase
        end else begin
            ip_sw_nxt_s = ip_sw_r;
        end
        if (ack_s) begin
            if (!exl_r) begin
                epc_nxt_s = int_bd ? (int_pc - 32'd4) : int_pc;
                bd_nxt_s  = int_bd;
            end else begin
                bd_nxt_s  = bd_r;
            end
            exc_code_nxt_s     = EXC_INT;
            exl_nxt_s          = 1'b1;
            flush_nxt_s        = 1'b1;
            flush_target_nxt_s = EXC_VECTOR;
        end else if (exc_valid) begin
            if (!exl_r) begin
                epc_nxt_s = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                bd_nxt_s  = exc_bd;
            end else begin
                bd_nxt_s  = bd_r;
            end
            if (exc_bad_valid) begin
                badvaddr_nxt_s = exc_badvaddr;
            end else begin
                badvaddr_nxt_s = badvaddr_r;
            end
            exc_code_nxt_s     = exc_code;
            exl_nxt_s          = 1'b1;
            flush_nxt_s        = 1'b1;
            flush_target_nxt_s = EXC_VECTOR;
        end else if (eret) begin
            exl_nxt_s          = 1'b0;
            flush_nxt_s        = 1'b1;
            flush_target_nxt_s = epc_r;
        end else begin
            flush_nxt_s = 1'b0;
        end
        int_req_nxt_s = ie_r && !exl_r && (|(ip_s & im_r)) && !int_ack && !exc_valid;
    end

    // Architectural CP0 state and registered pipeline-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_r           <= 8'd0;
            exl_r          <= 1'b0;
            ie_r           <= 1'b0;
            bd_r           <= 1'b0;
            ip_sw_r        <= 2'd0;
            exc_code_r     <= 5'd0;
            epc_r          <= EPC_RESET;
            badvaddr_r     <= EPC_RESET;
            int_req_r      <= 1'b0;
            flush_r        <= 1'b0;
            flush_target_r <= EXC_VECTOR;
        end else begin
            im_r           <= im_nxt_s;
            exl_r          <= exl_nxt_s;
            ie_r           <= ie_nxt_s;
            bd_r           <= bd_nxt_s;
            ip_sw_r        <= ip_sw_nxt_s;
            exc_code_r     <= exc_code_nxt_s;
            epc_r          <= epc_nxt_s;
            badvaddr_r     <= badvaddr_nxt_s;
            int_req_r      <= int_req_nxt_s;
            flush_r        <= flush_nxt_s;
            flush_target_r <= flush_target_nxt_s;
        end
    end

    // mfc0 view; a same-cycle mtc0 to the read address is forwarded.
    always_comb begin
        status_rd_s  = (wen && (waddr == CP0_STATUS))
                     ? pack_status(wdata[15:8], wdata[1], wdata[0])
                     : pack_status(im_r, exl_r, ie_r);
        cause_rd_s   = (wen && (waddr == CP0_CAUSE))
                     ? pack_cause(bd_r, ti_s, {ti_s, ip_hw_s, wdata[9:8]}, exc_code_r)
                     : pack_cause(bd_r, ti_s, ip_s, exc_code_r);
        count_rd_s   = (wen && (waddr == CP0_COUNT))   ? wdata : count_s;
        compare_rd_s = (wen && (waddr == CP0_COMPARE)) ? wdata : compare_s;
        epc_rd_s     = (wen && (waddr == CP0_EPC))     ? wdata : epc_r;
        case (raddr)
            CP0_BADVADDR: rdata = badvaddr_r;
            CP0_COUNT:    rdata = count_rd_s;
            CP0_COMPARE:  rdata = compare_rd_s;
            CP0_STATUS:   rdata = status_rd_s;
            CP0_CAUSE:    rdata = cause_rd_s;
            CP0_EPC:      rdata = epc_rd_s;
            default:      rdata = 32'd0;
        endcase
    end

    assign int_req      = int_req_r;
    assign flush        = flush_r;
    assign flush_target = flush_target_r;
    assign epc          = epc_r;

endmodule
